// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encoding and
// counter index map (also the rd_sel / ovf bit numbering).
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } perf_state_e;

  localparam int CYC_IDX  = 0;
  localparam int INS_IDX  = 1;
  localparam int EVT_BASE = 2;

endpackage

// File: rtl/perf_cnt_cell.sv
// One counter slice: synchronous clear, gated increment, wrap or saturate on
// overflow, and a sticky overflow flag.
module perf_cnt_cell #(
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (en_i && inc_i) begin
      if (&cnt_o) begin
        // Saturating counters sit at all-ones; wrapping ones roll to zero.
        ovf_o <= 1'b1;
        if (SATURATE == 0) cnt_o <= '0;
      end else begin
        cnt_o <= cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle, retired-instruction and generic event counters under one
// start/stop/clear FSM, with a registered read mux.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int NUM_EVT  = 4,
  parameter int SATURATE = 0,
  parameter int SEL_W    = $clog2(NUM_EVT + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               strcnt,
  input  logic               stpcnt,
  input  logic               clr,
  input  logic               inc_instr,
  input  logic [NUM_EVT-1:0] evt_inc,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic               running,
  output logic [NUM_EVT+1:0] ovf,
  output logic [1:0]         dbg_state
);

  localparam int NUM_CNT = NUM_EVT + 2;

  perf_state_e        state;
  logic [NUM_CNT-1:0] inc_vec;
  logic               cnt_clr;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [CNT_W-1:0]   rd_next;

  // strcnt clears like clr, so its own cycle is never counted.
  assign cnt_clr = clr | strcnt;
  assign cnt_en  = (state == RUN);
  assign inc_vec = {evt_inc, inc_instr, 1'b1};

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cell
    perf_cnt_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .inc_i (inc_vec[i]),
      .cnt_o (cnt[i]),
      .ovf_o (ovf[i])
    );
  end

  assign cycle_cnt = cnt[CYC_IDX];
  assign instr_cnt = cnt[INS_IDX];
  assign dbg_state = state;

  // Priority clr > strcnt > stpcnt; strcnt+stpcnt together is a zero-length window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (strcnt) begin
      state   <= stpcnt ? HALTED : RUN;
      running <= ~stpcnt;
    end else if (stpcnt && state == RUN) begin
      state   <= HALTED;
      running <= 1'b0;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == SEL_W'(i)) rd_next = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rd_next;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised successor to the pipeline's two fixed 16-bit perf counters: cycle and retired-instruction counters plus NUM_EVT generic event counters (stall, flush, mispredict, ...).
- All counters share a start/stop/clear FSM.
- Sits beside WB: start/stop/instr pulses come from the MEM/WB pipe register; event pulses come from hazard_detect and EX.
- Registered read mux exposes any counter to the ALU (ldic path) or MMIO.

Parameters:
CNT_W, 16, width of every counter
NUM_EVT, 4, number of generic event counters
SATURATE, 0, 0 = counters wrap at 2^CNT_W; 1 = counters hold at all-ones
SEL_W, $clog2(NUM_EVT+2), read-select width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
strcnt  in  1  start pulse (retiring strcnt instr)
stpcnt  in  1  stop pulse (retiring stpcnt instr)
clr  in  1  synchronous clear of all counters, flags and FSM
inc_instr  in  1  one instruction retired this cycle
evt_inc  in  NUM_EVT  per-event increment strobes
rd_sel  in  SEL_W  counter select: 0 = cycles, 1 = instrs, 2+k = event k
rd_data  out  CNT_W  registered selected counter value
cycle_cnt  out  CNT_W  live cycle counter
instr_cnt  out  CNT_W  live instruction counter
running  out  1  high in RUN state
ovf  out  NUM_EVT+2  sticky overflow flag per counter, same indexing as rd_sel

Behaviour:
- Reset (rst low, async): all counters 0, ovf 0, rd_data 0, state IDLE, running 0.
- FSM states: IDLE, RUN, HALTED. Priority per cycle: clr > strcnt > stpcnt.
- clr: all counters and ovf go to 0; state goes to IDLE next edge.
- strcnt: from any state, counters and ovf go to 0; state goes to RUN. The strcnt cycle itself is not counted.
- stpcnt in RUN: state goes to HALTED; counters hold. The stpcnt cycle IS counted (cycle +1; inc_instr/evt_inc honoured).
- stpcnt in IDLE or HALTED: no effect.
- strcnt and stpcnt in the same cycle: counters and ovf clear, state goes to HALTED (zero-length window).
- Counting in RUN only:
  - cycle_cnt +1 every cycle.
  - instr_cnt +1 when inc_instr.
  - event k +1 when evt_inc[k].
  - Increments are at most 1 per cycle per counter.
- Overflow, increment at all-ones:
  - SATURATE=0: counter wraps to 0, ovf[i] set.
  - SATURATE=1: counter holds all-ones, ovf[i] set.
  - ovf is sticky until clr, strcnt or reset.
- Read path:
  - rd_data is registered, 1-cycle latency.
  - rd_data at edge n+1 = counter value at edge n (pre-update of that cycle).
  - rd_sel >= NUM_EVT+2 returns 0.
- cycle_cnt and instr_cnt are the counter flops directly (0 latency).
- Reset mid-RUN: immediate return to reset values; no pending start survives.
- No combinational path from any input to any output.

Decomposition:
- Shared package perf_pkg:
  - state encoding (IDLE=2'b00, RUN=2'b01, HALTED=2'b10);
  - index constants CYC_IDX=0, INS_IDX=1, EVT_BASE=2.
- One sub-module, perf_cnt_cell, generated NUM_EVT+2 times:
  - inputs: clk, rst, clr_i, en_i, inc_i;
  - outputs: cnt_o, ovf_o;
  - parameters: CNT_W, SATURATE.
- FSM and read mux stay in perf_counter_bank.

Test Plan:
- Reset, strcnt pulse at cycle 2, 10 idle cycles, stpcnt at cycle 13 -> cycle_cnt=11, instr_cnt=0, running 1 over cycles 3-13, then 0; count frozen 20 cycles later.
- In RUN, inc_instr on 7 of 12 cycles, evt_inc[2] on 3 -> after stop: rd_sel=1 gives 7 and rd_sel=4 gives 3, each one cycle after rd_sel is applied; rd_sel=7 (NUM_EVT=4) gives 0.
- CNT_W=4, SATURATE=0, run 17 cycles -> cycle_cnt=1 and ovf[0]=1. With SATURATE=1 -> cycle_cnt=15 and ovf[0]=1. A following strcnt -> cnt=0, ovf=0.
- strcnt and stpcnt asserted together while counters are nonzero -> all counters 0, state HALTED, running 0. clr and strcnt together -> state IDLE, counters 0.
- rst driven low asynchronously mid-RUN with cycle_cnt=9 -> outputs 0 without waiting for a clk edge. After release, counting does not resume until a new strcnt.
